// File: rtl/pipe_pkg.sv
// Shared types for the OTTER decode/execute boundary: forwarding selects,
// in-flight producer descriptors and the ID/EX slot payload.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
  } prod_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    fwd_sel_t          fwd1;
    fwd_sel_t          fwd2;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
  } ex_slot_t;

  // A producer only matters if it will really write a non-x0 register.
  function automatic logic is_live(input prod_t p);
    return p.valid && p.rd_we && (p.rd != '0);
  endfunction

endpackage

// File: rtl/src_fwd_sel.sv
// Per-source operand resolution: picks the EX forwarding select for the two
// younger producers, otherwise bypasses the uncommitted writeback value.
module src_fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] adr,
  input  logic              used,
  input  prod_t             ex_prod,
  input  prod_t             mem_prod,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [XLEN-1:0]   rf_data,
  input  logic [XLEN-1:0]   wb_wd,
  output logic [XLEN-1:0]   operand_c,
  output fwd_sel_t          sel_c
);

  // Nearest producer wins; the WB write only patches the captured operand.
  always_comb begin
    operand_c = rf_data;
    sel_c     = FWD_NONE;
    if (used && (adr != '0)) begin
      if (is_live(ex_prod) && (ex_prod.rd == adr)) begin
        sel_c = FWD_EXMEM;
      end else if (is_live(mem_prod) && (mem_prod.rd == adr)) begin
        sel_c = FWD_MEMWB;
      end else if (wb_en && (wb_wa == adr)) begin
        operand_c = wb_wd;
      end
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand capture, forwarding-select precompute,
// load-use stall detection and flush/stall bubble insertion.
module id_ex_operand_stage
  import pipe_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ID_VALID,
  input  logic [REG_AW-1:0]    ID_RS1_ADR,
  input  logic [REG_AW-1:0]    ID_RS2_ADR,
  input  logic                 ID_RS1_USED,
  input  logic                 ID_RS2_USED,
  input  logic [REG_AW-1:0]    ID_RD,
  input  logic                 ID_RD_WE,
  input  logic                 ID_IS_LOAD,
  input  logic [XLEN-1:0]      ID_PC,
  input  logic [XLEN-1:0]      ID_IMM,
  input  logic [XLEN-1:0]      RF_RS1,
  input  logic [XLEN-1:0]      RF_RS2,
  input  logic [REG_AW-1:0]    WB_WA,
  input  logic [XLEN-1:0]      WB_WD,
  input  logic                 WB_EN,
  input  logic                 EX_FLUSH,
  output logic                 STALL,
  output logic                 EX_VALID,
  output logic [XLEN-1:0]      EX_OP1,
  output logic [XLEN-1:0]      EX_OP2,
  output fwd_sel_t             EX_FWD1,
  output fwd_sel_t             EX_FWD2,
  output logic [REG_AW-1:0]    EX_RD,
  output logic                 EX_RD_WE,
  output logic                 EX_IS_LOAD,
  output logic [XLEN-1:0]      EX_PC,
  output logic [XLEN-1:0]      EX_IMM
);

  ex_slot_t        ex_q;
  ex_slot_t        ex_d;
  prod_t           mem_q;
  prod_t           ex_prod;
  logic [XLEN-1:0] op1_c;
  logic [XLEN-1:0] op2_c;
  fwd_sel_t        sel1_c;
  fwd_sel_t        sel2_c;
  logic            load_use_c;

  assign ex_prod = '{valid: ex_q.valid, rd: ex_q.rd, rd_we: ex_q.rd_we};

  src_fwd_sel u_src1 (
    .adr       (ID_RS1_ADR),
    .used      (ID_RS1_USED),
    .ex_prod   (ex_prod),
    .mem_prod  (mem_q),
    .wb_en     (WB_EN),
    .wb_wa     (WB_WA),
    .rf_data   (RF_RS1),
    .wb_wd     (WB_WD),
    .operand_c (op1_c),
    .sel_c     (sel1_c)
  );

  src_fwd_sel u_src2 (
    .adr       (ID_RS2_ADR),
    .used      (ID_RS2_USED),
    .ex_prod   (ex_prod),
    .mem_prod  (mem_q),
    .wb_en     (WB_EN),
    .wb_wa     (WB_WA),
    .rf_data   (RF_RS2),
    .wb_wd     (WB_WD),
    .operand_c (op2_c),
    .sel_c     (sel2_c)
  );

  // Load result is not available until WB-side of MEM, so the consumer waits one cycle.
  always_comb begin
    load_use_c = 1'b0;
    if (ID_VALID && is_live(ex_prod) && ex_q.is_load) begin
      load_use_c = (ID_RS1_USED && (ID_RS1_ADR == ex_q.rd)) ||
                   (ID_RS2_USED && (ID_RS2_ADR == ex_q.rd));
    end
  end

  assign STALL = load_use_c && !EX_FLUSH && !RST;

  // Bubbles are fully zeroed so they can never look like a producer.
  always_comb begin
    ex_d = '0;
    if (!(RST || EX_FLUSH || STALL)) begin
      ex_d.valid   = ID_VALID;
      ex_d.op1     = op1_c;
      ex_d.op2     = op2_c;
      ex_d.fwd1    = sel1_c;
      ex_d.fwd2    = sel2_c;
      ex_d.rd      = ID_RD;
      ex_d.rd_we   = ID_RD_WE;
      ex_d.is_load = ID_IS_LOAD;
      ex_d.pc      = ID_PC;
      ex_d.imm     = ID_IMM;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_prod;
    end
  end

  assign EX_VALID   = ex_q.valid;
  assign EX_OP1     = ex_q.op1;
  assign EX_OP2     = ex_q.op2;
  assign EX_FWD1    = ex_q.fwd1;
  assign EX_FWD2    = ex_q.fwd2;
  assign EX_RD      = ex_q.rd;
  assign EX_RD_WE   = ex_q.rd_we;
  assign EX_IS_LOAD = ex_q.is_load;
  assign EX_PC      = ex_q.pc;
  assign EX_IMM     = ex_q.imm;

endmodule
